alu_mdu: RTL and testbench

//  Multi-cycle execute unit: the base ALU operations plus the RV32M/RV64M multiply/divide set.

---
 rtl/alu_mdu.sv | 279 +++++++++++++++++++++++++++
 tb/tb_alu_mdu.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// -----------------------------------------------------------------------------
// alu_mdu - execute-stage unit: single-cycle base ALU plus iterative RV32M/RV64M
// multiply/divide, behind a valid/ready handshake on both sides.
//
// Ports
//   clk        in   1     clock, all state updates on the rising edge
//   rst_n      in   1     synchronous reset, active-low
//   in_valid   in   1     operation request
//   in_ready   out  1     unit is idle and can accept a request
//   opcode     in   5     [4]=0: base op in [3:0]; [4]=1: M op, funct3 in [2:0]
//   rs1, rs2   in   XLEN  operands A and B
//   out_valid  out  1     result valid, held until out_ready
//   out_ready  in   1     consumer accepts the result
//   rd         out  XLEN  registered result
//   zero       out  1     registered flag, rd == 0
//
// Base op encoding (opcode[3:0]):
//   0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 CMP (signed <),
//   9 UCMP (unsigned <); 10..15 are undefined and return all ones.
// -----------------------------------------------------------------------------
module alu_mdu #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      opcode,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic            zero
);

    localparam int SHW     = $clog2(XLEN);
    localparam int CNTW    = $clog2(XLEN + 1);
    localparam int MUL_CYC = XLEN / MUL_STEP;

    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MUL = CNTW'(MUL_CYC);
    localparam logic [CNTW-1:0] CNT_DIV = CNTW'(XLEN);

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ALL_ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_CMP  = 4'd8;
    localparam logic [3:0] ALU_UCMP = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic [XLEN-1:0] base_op(
        input logic [3:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0] res;
        logic [SHW-1:0]  sh;
        sh = b[SHW-1:0];
        case (op)
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_SLL:  res = a << sh;
            ALU_SRL:  res = a >> sh;
            ALU_SRA:  res = $unsigned($signed(a) >>> sh);
            ALU_CMP:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_UCMP: res = {{(XLEN-1){1'b0}}, (a < b)};
            default:  res = ALL_ONES;
        endcase
        return res;
    endfunction

    state_e             state_q, state_d;
    logic [XLEN-1:0]    rd_q, rd_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               zero_q, zero_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;      // negate the final magnitude
    logic               sel_q, sel_d;      // mul: take high half; div: take remainder
    logic [2*XLEN-1:0]  acc_q, acc_d;      // mul: product; div: remainder in low half
    logic [2*XLEN-1:0]  mcand_q, mcand_d;  // mul: shifting multiplicand; div: divisor in low half
    logic [XLEN-1:0]    mplier_q, mplier_d; // mul: multiplier; div: dividend/quotient shifter

    logic [2:0]         f3_s;
    logic               is_divop_s;
    logic               a_neg_s, b_neg_s;
    logic [XLEN-1:0]    abs_a_s, abs_b_s;
    logic               last_s;
    logic [2*XLEN-1:0]  mul_acc_s, mul_prod_s;
    logic [XLEN-1:0]    mul_res_s;
    logic [XLEN:0]      div_part_s, div_diff_s;
    logic [XLEN-1:0]    div_rem_s, div_quo_s, div_pick_s, div_res_s;

    // Operand decode: signedness per M op and operand magnitudes.
    always_comb begin
        f3_s       = opcode[2:0];
        is_divop_s = f3_s[2];
        if (is_divop_s) begin
            a_neg_s = ~f3_s[0] & rs1[XLEN-1];
            b_neg_s = ~f3_s[0] & rs2[XLEN-1];
        end else begin
            a_neg_s = ((f3_s == 3'd1) || (f3_s == 3'd2)) & rs1[XLEN-1];
            b_neg_s = (f3_s == 3'd1) & rs2[XLEN-1];
        end
        abs_a_s = a_neg_s ? (ALL_ZERO - rs1) : rs1;
        abs_b_s = b_neg_s ? (ALL_ZERO - rs2) : rs2;
    end

    // Iterative datapath: one multiply step (MUL_STEP bits) and one restoring divide step.
    always_comb begin
        last_s    = (cnt_q == CNT_ONE);
        mul_acc_s = acc_q;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier_q[i]) begin
                mul_acc_s = mul_acc_s + (mcand_q << i);
            end else begin
                mul_acc_s = mul_acc_s;
            end
        end
        // Sign correction on the full-width product so high and low halves agree.
        mul_prod_s = neg_q ? ({(2*XLEN){1'b0}} - mul_acc_s) : mul_acc_s;
        mul_res_s  = sel_q ? mul_prod_s[2*XLEN-1:XLEN] : mul_prod_s[XLEN-1:0];

        div_part_s = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
        div_diff_s = div_part_s - {1'b0, mcand_q[XLEN-1:0]};
        if (!div_diff_s[XLEN]) begin
            div_rem_s = div_diff_s[XLEN-1:0];
            div_quo_s = {mplier_q[XLEN-2:0], 1'b1};
        end else begin
            div_rem_s = div_part_s[XLEN-1:0];
            div_quo_s = {mplier_q[XLEN-2:0], 1'b0};
        end
        div_pick_s = sel_q ? div_rem_s : div_quo_s;
        div_res_s  = neg_q ? (ALL_ZERO - div_pick_s) : div_pick_s;
    end

    // Control FSM next-state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        sel_d    = sel_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (!opcode[4]) begin
                        rd_d    = base_op(opcode[3:0], rs1, rs2);
                        state_d = S_DONE;
                    end else if (!is_divop_s) begin
                        is_div_d = 1'b0;
                        neg_d    = a_neg_s ^ b_neg_s;
                        sel_d    = (f3_s != 3'd0);
                        acc_d    = {(2*XLEN){1'b0}};
                        mcand_d  = {ALL_ZERO, abs_a_s};
                        mplier_d = abs_b_s;
                        cnt_d    = CNT_MUL;
                        state_d  = S_BUSY;
                    end else if (rs2 == ALL_ZERO) begin
                        rd_d    = f3_s[1] ? rs1 : ALL_ONES;
                        state_d = S_DONE;
                    end else if (!f3_s[0] && (rs1 == MIN_NEG) && (rs2 == ALL_ONES)) begin
                        rd_d    = f3_s[1] ? ALL_ZERO : MIN_NEG;
                        state_d = S_DONE;
                    end else begin
                        is_div_d = 1'b1;
                        // Remainder follows the dividend; quotient follows the xor of signs.
                        neg_d    = f3_s[1] ? a_neg_s : (a_neg_s ^ b_neg_s);
                        sel_d    = f3_s[1];
                        acc_d    = {(2*XLEN){1'b0}};
                        mcand_d  = {ALL_ZERO, abs_b_s};
                        mplier_d = abs_a_s;
                        cnt_d    = CNT_DIV;
                        state_d  = S_BUSY;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (is_div_q) begin
                    acc_d    = {ALL_ZERO, div_rem_s};
                    mplier_d = div_quo_s;
                    if (last_s) begin
                        rd_d    = div_res_s;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end else begin
                    acc_d    = mul_acc_s;
                    mcand_d  = mcand_q << MUL_STEP;
                    mplier_d = mplier_q >> MUL_STEP;
                    if (last_s) begin
                        rd_d    = mul_res_s;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        zero_d      = (rd_d == ALL_ZERO);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_q        <= ALL_ZERO;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            zero_q      <= 1'b1;
            cnt_q       <= {CNTW{1'b0}};
            is_div_q    <= 1'b0;
            neg_q       <= 1'b0;
            sel_q       <= 1'b0;
            acc_q       <= {(2*XLEN){1'b0}};
            mcand_q     <= {(2*XLEN){1'b0}};
            mplier_q    <= ALL_ZERO;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            zero_q      <= zero_d;
            cnt_q       <= cnt_d;
            is_div_q    <= is_div_d;
            neg_q       <= neg_d;
            sel_q       <= sel_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign rd        = rd_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_mdu.sv
// -----------------------------------------------------------------------------
// tb_alu_mdu - self-checking bench for alu_mdu (XLEN=32, MUL_STEP=1).
// A vector table of {opcode, rs1, rs2, expected rd, expected latency} is driven
// one op at a time; expectations go into a scoreboard queue at issue and are
// popped when out_valid appears. Hand-written sequences cover the DONE stall
// and reset in the middle of a divide.
// -----------------------------------------------------------------------------
module tb_alu_mdu;

    localparam logic [4:0] OP_ADD    = 5'h00;
    localparam logic [4:0] OP_SUB    = 5'h01;
    localparam logic [4:0] OP_AND    = 5'h02;
    localparam logic [4:0] OP_OR     = 5'h03;
    localparam logic [4:0] OP_XOR    = 5'h04;
    localparam logic [4:0] OP_SLL    = 5'h05;
    localparam logic [4:0] OP_SRL    = 5'h06;
    localparam logic [4:0] OP_SRA    = 5'h07;
    localparam logic [4:0] OP_CMP    = 5'h08;
    localparam logic [4:0] OP_UCMP   = 5'h09;
    localparam logic [4:0] OP_UNDEF  = 5'h0F;
    localparam logic [4:0] OP_MUL    = 5'h10;
    localparam logic [4:0] OP_MULH   = 5'h11;
    localparam logic [4:0] OP_MULHSU = 5'h12;
    localparam logic [4:0] OP_MULHU  = 5'h13;
    localparam logic [4:0] OP_DIV    = 5'h14;
    localparam logic [4:0] OP_DIVU   = 5'h15;
    localparam logic [4:0] OP_REM    = 5'h16;
    localparam logic [4:0] OP_REMU   = 5'h17;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  opcode = 5'h00;
    logic [31:0] rs1 = 32'h0;
    logic [31:0] rs2 = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] rd;
    logic        zero;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    alu_mdu #(.XLEN(32), .MUL_STEP(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp_rd = e; v.exp_lat = lat;
        vecs.push_back(v);
    endtask

    task automatic wait_ready(input string name);
        int t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({name, " in_ready"}, {63'h0, in_ready}, 64'h1);
    endtask

    // Drive one request at a negedge, hold it across the accepting edge, push the expectation.
    task automatic issue(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e, input int lat);
        exp_t x;
        wait_ready(name);
        opcode = op; rs1 = a; rs2 = b; in_valid = 1'b1;
        x.rd = e; x.lat = lat;
        sb.push_back(x);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at the first negedge after accept; waits for out_valid, compares, handshakes.
    task automatic collect(input string name);
        int   lat = 1;
        logic busy_ok = 1'b1;
        exp_t x;
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({name, " out_valid"}, {63'h0, out_valid}, 64'h1);
        check({name, " in_ready low while busy"}, {63'h0, busy_ok}, 64'h1);
        if (sb.size() == 0) begin
            check({name, " scoreboard entry"}, 64'h0, 64'h1);
        end else begin
            x = sb.pop_front();
            check({name, " rd"}, {32'h0, rd}, {32'h0, x.rd});
            check({name, " zero"}, {63'h0, zero}, {63'h0, (x.rd == 32'h0)});
            check({name, " latency"}, 64'(lat), 64'(x.lat));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " out_valid cleared"}, {63'h0, out_valid}, 64'h0);
        check({name, " in_ready after handshake"}, {63'h0, in_ready}, 64'h1);
    endtask

    initial begin
        add_vec(OP_ADD,    32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1);
        add_vec(OP_SUB,    32'h00000005, 32'h00000005, 32'h00000000, 1);
        add_vec(OP_AND,    32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1);
        add_vec(OP_OR,     32'h0000FF00, 32'h00FF0000, 32'h00FFFF00, 1);
        add_vec(OP_XOR,    32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1);
        add_vec(OP_SLL,    32'h00000001, 32'h0000003F, 32'h80000000, 1);
        add_vec(OP_SRL,    32'h80000000, 32'h00000004, 32'h08000000, 1);
        add_vec(OP_SRA,    32'h80000000, 32'h00000004, 32'hF8000000, 1);
        add_vec(OP_CMP,    32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1);
        add_vec(OP_UCMP,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
        add_vec(OP_UNDEF,  32'h12345678, 32'h9ABCDEF0, 32'hFFFFFFFF, 1);
        add_vec(OP_MUL,    32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 33);
        add_vec(OP_MULH,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33);
        add_vec(OP_MULHU,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, 33);
        add_vec(OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33);
        add_vec(OP_MULHSU, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, 33);
        add_vec(OP_MUL,    32'd12345,    32'd6789,     32'h04FED79D, 33);
        add_vec(OP_MUL,    32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0000000F, 33);
        add_vec(OP_MULH,   32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 33);
        add_vec(OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33);
        add_vec(OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33);
        add_vec(OP_DIVU,   32'd100,      32'd7,        32'd14,       33);
        add_vec(OP_REMU,   32'd100,      32'd7,        32'd2,        33);
        add_vec(OP_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        add_vec(OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33);
        add_vec(OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
        add_vec(OP_DIV,    32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1);
        add_vec(OP_REM,    32'h00000009, 32'h00000000, 32'h00000009, 1);
        add_vec(OP_DIVU,   32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1);
        add_vec(OP_REMU,   32'h00000005, 32'h00000000, 32'h00000005, 1);
        add_vec(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        add_vec(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", {63'h0, out_valid}, 64'h0);
        check("reset rd", {32'h0, rd}, 64'h0);
        check("reset in_ready", {63'h0, in_ready}, 64'h1);
        check("reset zero", {63'h0, zero}, 64'h1);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors
        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d op%0h", i, vecs[i].op);
            issue(nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_rd, vecs[i].exp_lat);
            collect(nm);
        end

        // DONE stall: result held, extra request ignored until after the handshake
        begin
            int   t = 1;
            exp_t x;
            issue("stall", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
            while (!out_valid && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("stall latency", 64'(t), 64'd33);
            opcode = OP_ADD; rs1 = 32'd1; rs2 = 32'd1; in_valid = 1'b1;
            for (int k = 0; k < 5; k++) begin
                check($sformatf("stall cyc%0d rd", k), {32'h0, rd}, 64'd14);
                check($sformatf("stall cyc%0d out_valid", k), {63'h0, out_valid}, 64'h1);
                check($sformatf("stall cyc%0d in_ready", k), {63'h0, in_ready}, 64'h0);
                @(negedge clk);
            end
            x = sb.pop_front();
            check("stall rd", {32'h0, rd}, {32'h0, x.rd});
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("stall no accept on handshake", {63'h0, out_valid}, 64'h0);
            check("stall in_ready after handshake", {63'h0, in_ready}, 64'h1);
            x.rd = 32'd2; x.lat = 1;
            sb.push_back(x);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            collect("stall next add");
        end

        // Reset in the middle of a divide
        wait_ready("rst");
        opcode = OP_DIV; rs1 = 32'd1000; rs2 = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("rst pre in_ready", {63'h0, in_ready}, 64'h0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst mid out_valid", {63'h0, out_valid}, 64'h0);
        check("rst mid rd", {32'h0, rd}, 64'h0);
        check("rst mid in_ready", {63'h0, in_ready}, 64'h1);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("rst aborted no output", {63'h0, out_valid}, 64'h0);
        issue("rst add", OP_ADD, 32'd2, 32'd3, 32'd5, 1);
        collect("rst add");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
